fp_unpack_pipe: RTL and testbench
=================================

// Module: fp_unpack_pipe
// PURPOSE
//  Pipelined, multi-format FP operand unpacker and classifier for the FPU front end.
//  - Takes one raw FLEN-bit register operand per transfer. Format is single, or double when FLEN=64.
//  - Produces the sign, unbiased exponent, normalised significand (subnormals pre-shifted)
//    and the 10-bit RISC-V fclass vector.
//  - Adds NaN-box checking, valid/ready flow control, flush and tag passthrough.
//  - Sits between the FP register file read and the FPU execute units.
// PARAMETERS
//  FLEN   64  datapath width. Legal values: 32 (single only) or 64 (single+double).
//  TAG_W  4   width of the opaque tag carried alongside each operand.
// PORTS
//  clk_i        in   1          clock
//  rst_i        in   1          synchronous active-high reset
//  flush_i      in   1          drop all in-flight operands
//  in_valid_i   in   1          operand valid
//  in_ready_o   out  1          unit can accept an operand this cycle
//  opd_i        in   FLEN       raw register contents
//  fmt_i        in   1          0=single, 1=double (ignored and treated as 0 when FLEN=32)
//  tag_i        in   TAG_W      sideband tag
//  out_valid_o  out  1          result valid
//  out_ready_i  in   1          consumer accepts the result
//  sign_o       out  1          operand sign
//  exp_o        out  13         signed unbiased exponent, sized for double (11+2)
//  sig_o        out  53         significand with the leading 1 at bit 52 (double) or bit 23 (single)
//  fclass_o     out  10         one-hot class: 9 qNaN, 8 sNaN, 7 +inf, 6 +norm, 5 +sub,
//                               4 +0, 3 -0, 2 -sub, 1 -norm, 0 -inf
//  tag_o        out  TAG_W      tag of the result
// BEHAVIOUR
//  - Clocking and reset: one clock, clk_i; synchronous active-high reset rst_i.
//    Reset clears both stage valids. Reset values of all outputs: out_valid_o=0, all data outputs 0.
//    in_ready_o is 1 on the first cycle after reset.
//  - Pipeline: two register stages; latency is 2 cycles from the accepting edge to out_valid_o.
//    S1 captures opd/fmt/tag, then classifies and computes the leading-zero count.
//    S2 holds the final shift result and drives the outputs directly from its registers.
//  - Handshake: a transfer occurs on an edge where valid&&ready.
//    adv2 = !s2_valid | out_ready_i;  adv1 = !s1_valid | adv2;  in_ready_o = adv1.
//    Throughput is 1 per cycle with no bubbles.
//    Under stall, S2 outputs are held stable. in_ready_o falls only when both stages are full
//    and out_ready_i=0.
//  - flush_i: synchronously clears both valids. An input presented in the same cycle is dropped.
//    flush_i has priority over a handshake. rst_i has priority over everything.
//  - Field extraction:
//    single: e=bits[30:23], f=bits[22:0], bias 127.
//    double: e=bits[62:52], f=bits[51:0], bias 1023.
//  - NaN-box: when FLEN=64 and fmt=single, bits[63:32] must be all ones. Otherwise the operand is
//    replaced by the canonical qNaN 0x7FC00000: sign 0, class bit 9.
//  - Class decode:
//    e all-ones & f[msb]=1 -> qNaN.
//    e all-ones & f[msb]=0 & f!=0 -> sNaN.
//    e all-ones & f=0 -> inf.
//    e=0 & f!=0 -> subnormal.
//    e=0 & f=0 -> zero.
//    Anything else -> normal.
//    Sign selects the +/- bit for inf, normal, subnormal and zero. Exactly one fclass bit is set.
//  - Normal, inf and NaN: exp_o = e - bias (inf/NaN give 128 or 1024); sig_o = {1,f}, zero-extended.
//  - Subnormal: lz = leading zeros of f within its field; sh = lz+1;
//    exp_o = (1-bias) - sh; sig_o = f << sh.
//    Single 0x00000001 gives exp -149. Double min subnormal gives exp -1074.
//  - Zero: exp_o=0, sig_o=0.
//  - Width rules: all exponent arithmetic is done in 13-bit signed; it cannot overflow. For single,
//    sig_o[52:24] is 0. sign_o is the raw sign bit, except 0 for canonicalised NaN.
// STRUCTURE
//  - fpu_pkg: fclass bit indices, FMT_S/FMT_D constants, bias and width constants per format,
//    canonical-NaN constant.
//  - One sub-module: the existing CLZ counter, instantiated once, 64 bits wide.
//    The fraction is left-aligned into it, so a single instance serves both formats.
//  - Everything else is inline: two stage registers plus valid/ready logic.
// TESTING
//  1. Boxed single 1.0, opd 0xFFFFFFFF_3F800000, fmt 0 -> after 2 cycles: exp 0, sig 0x800000,
//     fclass bit 6, sign 0.
//  2. Boxed single 0xFFFFFFFF_00000001 -> exp -149, sig 0x800000, fclass bit 5.
//     Double 0x0000000000000001 -> exp -1074, sig bit 52 set, fclass bit 5.
//  3. Unboxed single 0x00000000_3F800000 -> fclass bit 9, sign 0.
//     Double 0xFFF0000000000000 -> fclass bit 0, exp 1024.
//     Double 0x7FF0000000000001 -> fclass bit 8.
//  4. Back-pressure: stream tags 1..5 back-to-back with out_ready_i=0 for 4 cycles, then 1 ->
//     exactly 2 accepted before in_ready_o=0. Outputs stable while stalled. Tags emerge 1..5 in
//     order with no loss or duplication. Full rate once released.
//  5. flush_i asserted with both stages full while in_valid_i=1 -> next cycle out_valid_o=0,
//     in_ready_o=1, and the flushed tags never appear.
//  6. rst_i pulsed mid-stream -> next cycle out_valid_o=0 and all data outputs 0.
//     The first operand sent after reset appears exactly 2 cycles after it is accepted.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP format constants, fclass bit indices and the unpacked-operand record
package fpu_pkg;
  localparam logic FMT_S = 1'b0;
  localparam logic FMT_D = 1'b1;
  localparam int EXP_W = 13;
  localparam int SIG_W = 53;
  localparam int FCLASS_W = 10;
  localparam logic [EXP_W-1:0] BIAS_S = 13'd127;
  localparam logic [EXP_W-1:0] BIAS_D = 13'd1023;
  localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
  localparam int FC_NINF = 0;
  localparam int FC_NNORM = 1;
  localparam int FC_NSUB = 2;
  localparam int FC_NZERO = 3;
  localparam int FC_PZERO = 4;
  localparam int FC_PSUB = 5;
  localparam int FC_PNORM = 6;
  localparam int FC_PINF = 7;
  localparam int FC_SNAN = 8;
  localparam int FC_QNAN = 9;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic [FCLASS_W-1:0] fclass;
  } unpacked_t;
endpackage

// File: rtl/fp_unpack_pipe_clz.sv
// fp_unpack_pipe_clz: 64-bit leading-zero counter, returns 64 for an all-zero input
module fp_unpack_pipe_clz (
  input  logic [63:0] i_val,
  output logic [6:0]  o_lz
);
  always_comb begin
    o_lz = 7'd64;
    for (int i = 0; i < 64; i++)
      if (i_val[i]) o_lz = 7'(63 - i);
  end
endmodule

// File: rtl/fp_unpack_pipe.sv
// fp_unpack_pipe: two-stage FP operand unpacker/classifier with NaN-box check and valid/ready flow
module fp_unpack_pipe
  import fpu_pkg::*;
#(
  parameter int FLEN  = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [FLEN-1:0]  opd_i,
  input  logic             fmt_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             sign_o,
  output logic [12:0]      exp_o,
  output logic [52:0]      sig_o,
  output logic [9:0]       fclass_o,
  output logic [TAG_W-1:0] tag_o
);
  logic r1_valid, r2_valid, r1_fmt;
  logic [FLEN-1:0] r1_opd;
  logic [TAG_W-1:0] r1_tag, r2_tag;
  unpacked_t r2_res, w_res;
  logic w_adv1, w_adv2, w_d, w_box_ok, w_sign, w_emax, w_ezero, w_fnz, w_fmsb;
  logic w_qnan, w_snan, w_inf, w_sub, w_zero;
  logic [63:0] w_x, w_fal, w_sh;
  logic [31:0] w_s;
  logic [12:0] w_e, w_bias;
  logic [6:0] w_lz;
  logic [3:0] w_idx;
  assign w_adv2 = !r2_valid || out_ready_i;
  assign w_adv1 = !r1_valid || w_adv2;
  assign in_ready_o = w_adv1;
  assign w_x = 64'(r1_opd);
  assign w_d = FLEN == 64 && r1_fmt == FMT_D;
  assign w_box_ok = w_d || FLEN == 32 || &w_x[63:32];
  assign w_s = w_box_ok ? w_x[31:0] : CANON_NAN_S;
  assign w_sign = w_d ? w_x[63] : w_s[31];
  assign w_e = w_d ? {2'b0, w_x[62:52]} : {5'b0, w_s[30:23]};
  assign w_bias = w_d ? BIAS_D : BIAS_S;
  assign w_emax = w_d ? &w_x[62:52] : &w_s[30:23];
  assign w_ezero = w_e == '0;
  // fraction left-aligned to bit 63 so one counter serves both formats
  assign w_fal = w_d ? {w_x[51:0], 12'b0} : {w_s[22:0], 41'b0};
  assign w_fnz = |w_fal;
  assign w_fmsb = w_fal[63];
  fp_unpack_pipe_clz u_clz (.i_val(w_fal), .o_lz(w_lz));
  assign w_sh = w_fal << w_lz;
  assign w_qnan = w_emax && w_fmsb;
  assign w_snan = w_emax && !w_fmsb && w_fnz;
  assign w_inf = w_emax && !w_fnz;
  assign w_sub = w_ezero && w_fnz;
  assign w_zero = w_ezero && !w_fnz;
  assign w_idx = 4'(w_qnan ? FC_QNAN : w_snan ? FC_SNAN :
                    w_inf  ? (w_sign ? FC_NINF  : FC_PINF)  :
                    w_zero ? (w_sign ? FC_NZERO : FC_PZERO) :
                    w_sub  ? (w_sign ? FC_NSUB  : FC_PSUB)  :
                             (w_sign ? FC_NNORM : FC_PNORM));
  always_comb begin
    w_res.sign = w_sign;
    w_res.exp = w_zero ? '0 : w_sub ? (13'd1 - w_bias) - (13'(w_lz) + 13'd1) : w_e - w_bias;
    w_res.sig = w_zero ? '0 :
                w_sub  ? (w_d ? 53'(w_sh >> 11) : 53'(w_sh >> 40)) :
                         (w_d ? {1'b1, w_x[51:0]} : 53'({1'b1, w_s[22:0]}));
    w_res.fclass = 10'd1 << w_idx;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
    end else begin
      if (w_adv1) r1_valid <= in_valid_i;
      if (w_adv2) r2_valid <= r1_valid;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r1_opd <= '0;
      r1_fmt <= 1'b0;
      r1_tag <= '0;
      r2_res <= '0;
      r2_tag <= '0;
    end else begin
      if (w_adv1 && in_valid_i) begin
        r1_opd <= opd_i;
        r1_fmt <= fmt_i;
        r1_tag <= tag_i;
      end
      if (w_adv2 && r1_valid) begin
        r2_res <= w_res;
        r2_tag <= r1_tag;
      end
    end
  end
  assign out_valid_o = r2_valid;
  assign {sign_o, exp_o, sig_o, fclass_o} = r2_res;
  assign tag_o = r2_tag;
endmodule

// File: tb/tb_fp_unpack_pipe.sv
// tb_fp_unpack_pipe: table-driven scoreboard bench for the FP unpack pipeline
module tb_fp_unpack_pipe;
  typedef struct {
    logic [63:0] opd;
    logic        fmt;
    logic        sign;
    logic [12:0] exp;
    logic [52:0] sig;
    int          cls;
  } vec_t;
  typedef struct {
    int         idx;
    logic [3:0] tag;
  } sb_t;
  logic clk = 1'b0, rst, flush, in_valid, in_ready_o, fmt, out_valid_o, out_ready, sign_o;
  logic [63:0] opd;
  logic [3:0] tag, tag_o;
  logic [12:0] exp_o;
  logic [52:0] sig_o;
  logic [9:0] fclass_o;
  vec_t vec[18];
  sb_t sb[$];
  sb_t it;
  int cur_idx = 0, n_chk = 0, n_fail = 0, n_acc;
  fp_unpack_pipe #(.FLEN(64), .TAG_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .opd_i(opd), .fmt_i(fmt), .tag_i(tag), .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .sign_o(sign_o), .exp_o(exp_o), .sig_o(sig_o), .fclass_o(fclass_o), .tag_o(tag_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int k, input logic [3:0] t);
    in_valid = 1'b1;
    opd = vec[k].opd;
    fmt = vec[k].fmt;
    tag = t;
    cur_idx = k;
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || out_valid_o) && n < 30) begin
      step();
      n++;
    end
    chk("drain_left", 64'(sb.size()), 0);
  endtask
  always @(negedge clk) begin
    if (out_valid_o === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got tag %0h, required no output", tag_o);
      end else begin
        it = sb.pop_front();
        chk("tag", 64'(tag_o), 64'(it.tag));
        chk("sign", 64'(sign_o), 64'(vec[it.idx].sign));
        chk("exp", 64'(exp_o), 64'(vec[it.idx].exp));
        chk("sig", 64'(sig_o), 64'(vec[it.idx].sig));
        chk("fclass", 64'(fclass_o), 64'(10'd1 << vec[it.idx].cls));
      end
    end
    if (rst || flush) sb.delete();
    else if (in_valid && in_ready_o === 1'b1) sb.push_back('{cur_idx, tag});
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vec[0]  = '{64'hFFFFFFFF_3F800000, 1'b0, 1'b0, 13'd0,      53'h800000,           6};
    vec[1]  = '{64'hFFFFFFFF_00000001, 1'b0, 1'b0, 13'h1F6B,   53'h800000,           5};
    vec[2]  = '{64'h00000000_00000001, 1'b1, 1'b0, 13'h1BCE,   53'h10000000000000,   5};
    vec[3]  = '{64'h00000000_3F800000, 1'b0, 1'b0, 13'd128,    53'hC00000,           9};
    vec[4]  = '{64'hFFF00000_00000000, 1'b1, 1'b1, 13'd1024,   53'h10000000000000,   0};
    vec[5]  = '{64'h7FF00000_00000001, 1'b1, 1'b0, 13'd1024,   53'h10000000000001,   8};
    vec[6]  = '{64'hFFFFFFFF_80000000, 1'b0, 1'b1, 13'd0,      53'h0,                3};
    vec[7]  = '{64'h00000000_00000000, 1'b1, 1'b0, 13'd0,      53'h0,                4};
    vec[8]  = '{64'h3FF00000_00000000, 1'b1, 1'b0, 13'd0,      53'h10000000000000,   6};
    vec[9]  = '{64'hFFFFFFFF_C0490FDB, 1'b0, 1'b1, 13'd1,      53'hC90FDB,           1};
    vec[10] = '{64'hFFFFFFFF_7FC00000, 1'b0, 1'b0, 13'd128,    53'hC00000,           9};
    vec[11] = '{64'hFFFFFFFF_FF800000, 1'b0, 1'b1, 13'd128,    53'h800000,           0};
    vec[12] = '{64'h000FFFFF_FFFFFFFF, 1'b1, 1'b0, 13'h1C01,   53'h1FFFFFFFFFFFFE,   5};
    vec[13] = '{64'h80000000_00000000, 1'b1, 1'b1, 13'd0,      53'h0,                3};
    vec[14] = '{64'hFFFFFFFF_00400000, 1'b0, 1'b0, 13'h1F81,   53'h800000,           5};
    vec[15] = '{64'hFFFFFFFF_7F7FFFFF, 1'b0, 1'b0, 13'd127,    53'hFFFFFF,           6};
    vec[16] = '{64'hFFFFFFFE_3F800000, 1'b0, 1'b0, 13'd128,    53'hC00000,           9};
    vec[17] = '{64'h80000000_00000001, 1'b1, 1'b1, 13'h1BCE,   53'h10000000000000,   2};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; opd = '0; fmt = 1'b0; tag = '0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid_o), 0);
    chk("rst_in_ready", 64'(in_ready_o), 1);
    chk("rst_exp", 64'(exp_o), 0);
    chk("rst_sig", 64'(sig_o), 0);
    chk("rst_misc", 64'({sign_o, fclass_o, tag_o}), 0);
    drive(0, 4'h0);
    step();
    in_valid = 1'b0;
    chk("lat_cycle1_valid", 64'(out_valid_o), 0);
    step();
    chk("lat_cycle2_valid", 64'(out_valid_o), 1);
    drain();
    for (int i = 0; i < 18; i++) begin
      drive(i, 4'(i));
      step();
    end
    drain();
    out_ready = 1'b0;
    n_acc = 0;
    drive(1, 4'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_ready_o) n_acc++;
      if (c >= 2) begin
        chk("stall_valid", 64'(out_valid_o), 1);
        chk("stall_tag", 64'(tag_o), 1);
        chk("stall_sig", 64'(sig_o), 64'(vec[1].sig));
      end
      @(posedge clk);
      #1;
      drive(1 + n_acc, 4'(1 + n_acc));
    end
    chk("bp_accepted", 64'(n_acc), 2);
    chk("bp_in_ready", 64'(in_ready_o), 0);
    out_ready = 1'b1;
    for (int k = 1 + n_acc; k <= 5; k++) begin
      drive(k, 4'(k));
      @(negedge clk);
      chk("full_rate_ready", 64'(in_ready_o), 1);
      @(posedge clk);
      #1;
    end
    drain();
    out_ready = 1'b0;
    drive(6, 4'hA);
    step();
    drive(7, 4'hB);
    step();
    drive(8, 4'hC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid_o), 0);
    chk("flush_in_ready", 64'(in_ready_o), 1);
    out_ready = 1'b1;
    repeat (4) step();
    chk("flush_quiet", 64'(out_valid_o), 0);
    drive(9, 4'h9);
    step();
    drain();
    drive(10, 4'hA);
    step();
    drive(11, 4'hB);
    step();
    drive(12, 4'hC);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid_o), 0);
    chk("mid_rst_exp", 64'(exp_o), 0);
    chk("mid_rst_sig", 64'(sig_o), 0);
    chk("mid_rst_misc", 64'({sign_o, fclass_o, tag_o}), 0);
    drive(15, 4'h5);
    step();
    in_valid = 1'b0;
    chk("post_rst_cycle1_valid", 64'(out_valid_o), 0);
    step();
    chk("post_rst_cycle2_valid", 64'(out_valid_o), 1);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
